// File: rtl/led_bar_monitor.sv
// Receive-side checker for a thermometer-coded LED bar: decodes the lit level,
// tracks ramp direction and turning points, and flags illegal codes and steps.
module led_bar_monitor #(
    parameter int unsigned LED_W    = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned END_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LED_W-1:0]           led,
    input  logic                       clear,
    output logic [$clog2(LED_W+1)-1:0] level,
    output logic                       code_ok,
    output logic [1:0]                 dir,
    output logic                       turn_valid,
    output logic [$clog2(LED_W+1)-1:0] turn_level,
    output logic                       step_err,
    output logic                       code_err,
    output logic                       seq_done,
    output logic [CNT_W-1:0]           seq_count,
    output logic [CNT_W-1:0]           err_count
);

    localparam int unsigned LVL_W  = $clog2(LED_W + 1);
    localparam int unsigned DLT_W  = LVL_W + 1;
    localparam int unsigned HOLD_W = $clog2(END_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_BOTTOM,
        S_ERR
    } state_e;

    logic [LED_W-1:0]        led_q;
    state_e                  state_q, state_d;
    logic [LVL_W-1:0]        prev_q, prev_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;

    logic [LVL_W-1:0]        level_d;
    logic                    code_ok_d;
    logic [1:0]              dir_d;
    logic                    turn_valid_d;
    logic [LVL_W-1:0]        turn_level_d;
    logic                    step_err_d;
    logic                    code_err_d;
    logic                    seq_done_d;
    logic [CNT_W-1:0]        seq_count_d;
    logic [CNT_W-1:0]        err_count_d;

    logic                    legal_c;
    logic [LVL_W-1:0]        lvl_c;
    logic signed [DLT_W-1:0] delta_c;
    logic                    dlt_up_c;
    logic                    dlt_dn_c;
    logic                    dlt_zero_c;
    logic                    err_ev_c;

    // Decode the registered sample: legality, lit level and signed step.
    always_comb begin
        legal_c = ((led_q & (led_q + LED_W'(1))) == '0);
        lvl_c   = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (led_q[i]) lvl_c = LVL_W'(i + 1);
        end
        delta_c    = $signed({1'b0, lvl_c}) - $signed({1'b0, prev_q});
        dlt_up_c   = (delta_c == DLT_W'(1));
        dlt_dn_c   = (delta_c == '1);
        dlt_zero_c = (delta_c == '0);
    end

    // Direction tracking, turn detection and error classification.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        hold_d       = hold_q;
        level_d      = level;
        code_ok_d    = legal_c;
        turn_valid_d = 1'b0;
        turn_level_d = turn_level;
        step_err_d   = 1'b0;
        code_err_d   = 1'b0;
        seq_done_d   = 1'b0;

        if (!legal_c) begin
            code_err_d = 1'b1;
            state_d    = S_ERR;
        end else begin
            level_d = lvl_c;
            prev_d  = lvl_c;
            case (state_q)
                S_IDLE: begin
                    if (lvl_c == LVL_W'(1)) begin
                        state_d = S_UP;
                    end else if (lvl_c != '0) begin
                        step_err_d = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_UP: begin
                    if (dlt_dn_c) begin
                        turn_valid_d = 1'b1;
                        turn_level_d = prev_q;
                        state_d      = S_DOWN;
                    end else if (!dlt_up_c && !dlt_zero_c) begin
                        step_err_d = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_DOWN: begin
                    if (dlt_dn_c) begin
                        if (lvl_c == '0) begin
                            state_d = S_BOTTOM;
                            hold_d  = '0;
                        end
                    end else if (dlt_up_c) begin
                        turn_valid_d = 1'b1;
                        turn_level_d = prev_q;
                        state_d      = S_UP;
                    end else if (!dlt_zero_c) begin
                        step_err_d = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_BOTTOM: begin
                    if (lvl_c == '0) begin
                        hold_d = hold_q + HOLD_W'(1);
                        if (hold_d == HOLD_W'(END_HOLD)) begin
                            seq_done_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else if (lvl_c == LVL_W'(1)) begin
                        turn_valid_d = 1'b1;
                        turn_level_d = '0;
                        state_d      = S_UP;
                    end else begin
                        step_err_d = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_ERR: begin
                    if (lvl_c == '0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_UP:             dir_d = 2'b01;
            S_DOWN, S_BOTTOM: dir_d = 2'b10;
            S_ERR:            dir_d = 2'b11;
            default:          dir_d = 2'b00;
        endcase
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        err_ev_c    = step_err_d | code_err_d;
        seq_count_d = seq_count;
        err_count_d = err_count;
        if (clear) begin
            seq_count_d = '0;
            err_count_d = '0;
        end else begin
            if (seq_done_d && (seq_count != '1)) seq_count_d = seq_count + CNT_W'(1);
            if (err_ev_c && (err_count != '1))   err_count_d = err_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q      <= '0;
            state_q    <= S_IDLE;
            prev_q     <= '0;
            hold_q     <= '0;
            level      <= '0;
            code_ok    <= 1'b0;
            dir        <= 2'b00;
            turn_valid <= 1'b0;
            turn_level <= '0;
            step_err   <= 1'b0;
            code_err   <= 1'b0;
            seq_done   <= 1'b0;
            seq_count  <= '0;
            err_count  <= '0;
        end else begin
            led_q      <= led;
            state_q    <= state_d;
            prev_q     <= prev_d;
            hold_q     <= hold_d;
            level      <= level_d;
            code_ok    <= code_ok_d;
            dir        <= dir_d;
            turn_valid <= turn_valid_d;
            turn_level <= turn_level_d;
            step_err   <= step_err_d;
            code_err   <= code_err_d;
            seq_done   <= seq_done_d;
            seq_count  <= seq_count_d;
            err_count  <= err_count_d;
        end
    end

endmodule

// File: tb/tb_led_bar_monitor.sv
// Bench for led_bar_monitor: directed flasher scenarios plus a random walk,
// all outputs compared every cycle against a behavioural model.
module tb_led_bar_monitor;

    localparam int END_HOLD = 4;
    localparam int CMAX     = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] led;
    logic        clear;
    logic [4:0]  level;
    logic        code_ok;
    logic [1:0]  dir;
    logic        turn_valid;
    logic [4:0]  turn_level;
    logic        step_err;
    logic        code_err;
    logic        seq_done;
    logic [7:0]  seq_count;
    logic [7:0]  err_count;

    led_bar_monitor #(.LED_W(16), .CNT_W(8), .END_HOLD(END_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .led        (led),
        .clear      (clear),
        .level      (level),
        .code_ok    (code_ok),
        .dir        (dir),
        .turn_valid (turn_valid),
        .turn_level (turn_level),
        .step_err   (step_err),
        .code_err   (code_err),
        .seq_done   (seq_done),
        .seq_count  (seq_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Behavioural model: phases of the ramp, plain integers throughout.
    localparam int P_IDLE = 0, P_RISE = 1, P_FALL = 2, P_FLOOR = 3, P_BAD = 4;
    int          m_phase, m_prev, m_hold;
    int          m_level, m_ok, m_dir, m_tv, m_tl, m_se, m_ce, m_sd, m_sc, m_ec;
    logic [15:0] m_ledq;

    function automatic int thermo_len(input logic [15:0] v);
        logic [16:0] t;
        for (int n = 0; n <= 16; n++) begin
            t = (17'd1 << n) - 17'd1;
            if ({1'b0, v} == t) return n;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE; m_prev = 0; m_hold = 0; m_ledq = '0;
        m_level = 0; m_ok = 0; m_dir = 0; m_tv = 0; m_tl = 0;
        m_se = 0; m_ce = 0; m_sd = 0; m_sc = 0; m_ec = 0;
    endtask

    task automatic m_step(input logic [15:0] v, input bit clr);
        int n, d;
        m_tv = 0; m_se = 0; m_ce = 0; m_sd = 0;
        n = thermo_len(v);
        if (n < 0) begin
            m_ok = 0; m_ce = 1; m_phase = P_BAD;
        end else begin
            m_ok = 1; m_level = n; d = n - m_prev;
            case (m_phase)
                P_IDLE:  if (n == 1) m_phase = P_RISE;
                         else if (n != 0) begin m_se = 1; m_phase = P_BAD; end
                P_RISE:  if (d == -1) begin m_tv = 1; m_tl = m_prev; m_phase = P_FALL; end
                         else if (d > 1 || d < -1) begin m_se = 1; m_phase = P_BAD; end
                P_FALL:  if (d == -1) begin
                             if (n == 0) begin m_phase = P_FLOOR; m_hold = 0; end
                         end else if (d == 1) begin m_tv = 1; m_tl = m_prev; m_phase = P_RISE; end
                         else if (d != 0) begin m_se = 1; m_phase = P_BAD; end
                P_FLOOR: if (n == 0) begin
                             m_hold++;
                             if (m_hold == END_HOLD) begin m_sd = 1; m_phase = P_IDLE; end
                         end else if (n == 1) begin m_tv = 1; m_tl = 0; m_phase = P_RISE; end
                         else begin m_se = 1; m_phase = P_BAD; end
                default: if (n == 0) m_phase = P_IDLE;
            endcase
            m_prev = n;
        end
        if (clr) m_ec = 0; else if ((m_se || m_ce) && m_ec < CMAX) m_ec++;
        if (clr) m_sc = 0; else if (m_sd && m_sc < CMAX) m_sc++;
        case (m_phase)
            P_RISE:          m_dir = 1;
            P_FALL, P_FLOOR: m_dir = 2;
            P_BAD:           m_dir = 3;
            default:         m_dir = 0;
        endcase
    endtask

    task automatic check_all();
        check("level",      level,      m_level);
        check("code_ok",    code_ok,    m_ok);
        check("dir",        dir,        m_dir);
        check("turn_valid", turn_valid, m_tv);
        check("turn_level", turn_level, m_tl);
        check("step_err",   step_err,   m_se);
        check("code_err",   code_err,   m_ce);
        check("seq_done",   seq_done,   m_sd);
        check("seq_count",  seq_count,  m_sc);
        check("err_count",  err_count,  m_ec);
    endtask

    int turns[$];
    int n_se, n_ce, n_sd;

    // Entered and left at a falling edge: drive, clock, model, compare.
    task automatic tick(input logic [15:0] v, input bit clr);
        led = v; clear = clr;
        @(posedge clk);
        m_step(m_ledq, clr);
        m_ledq = v;
        @(negedge clk);
        check_all();
        if (turn_valid) turns.push_back(int'(turn_level));
        if (step_err) n_se++;
        if (code_err) n_ce++;
        if (seq_done) n_sd++;
    endtask

    function automatic logic [15:0] bar(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic tick_l(input int n);
        tick(bar(n), 1'b0);
    endtask

    task automatic ramp(input int from, input int to);
        if (to > from) for (int n = from + 1; n <= to; n++) tick_l(n);
        else           for (int n = from - 1; n >= to; n--) tick_l(n);
    endtask

    task automatic do_reset();
        reset = 1'b0; led = '0; clear = 1'b0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        turns.delete(); n_se = 0; n_ce = 0; n_sd = 0;
    endtask

    initial begin
        int lvl, up, r;
        logic [15:0] v;
        reset = 1'b0; led = '0; clear = 1'b0;
        m_reset();
        @(negedge clk);
        do_reset();

        // Flasher golden run
        tick_l(0);
        ramp(0, 16);  tick_l(16);
        ramp(16, 6);  tick_l(6);
        ramp(6, 11);  tick_l(11);
        ramp(11, 0);  tick_l(0);
        ramp(0, 6);   tick_l(6);
        ramp(6, 0);
        repeat (10) tick_l(0);
        check("gold_turns", turns.size(), 5);
        if (turns.size() == 5) begin
            check("gold_t0", turns[0], 16);
            check("gold_t1", turns[1], 6);
            check("gold_t2", turns[2], 11);
            check("gold_t3", turns[3], 0);
            check("gold_t4", turns[4], 6);
        end
        check("gold_done", n_sd, 1);
        check("gold_seq", seq_count, 1);
        check("gold_err", err_count, 0);

        // Bad code held for three samples
        do_reset();
        repeat (3) tick(16'h0005, 1'b0);
        check("bad_dir", dir, 3);
        tick(16'h0000, 1'b0);
        tick(16'h0000, 1'b0);
        check("bad_ce", n_ce, 3);
        check("bad_err", err_count, 3);
        check("bad_idle", dir, 0);

        // Jump from level 5 to 9
        do_reset();
        ramp(0, 5);
        repeat (3) tick(16'h01FF, 1'b0);
        check("jump_se", n_se, 1);
        check("jump_dir", dir, 3);
        check("jump_err", err_count, 1);
        check("jump_turns", turns.size(), 0);

        // Early restart from the bottom
        do_reset();
        ramp(0, 3); tick_l(3);
        ramp(3, 0); tick_l(0); tick_l(0);
        tick_l(1); tick_l(1);
        check("early_done", n_sd, 0);
        check("early_turn", turns.size() > 0 ? turns[$] : -1, 0);
        check("early_dir", dir, 1);

        // Error counter saturation and clear priority
        do_reset();
        repeat (300) tick(16'h0005, 1'b0);
        check("sat_err", err_count, CMAX);
        tick(16'h0005, 1'b1);
        check("clr_err", err_count, 0);
        check("clr_ce", code_err, 1);

        // Asynchronous reset mid-ramp
        do_reset();
        ramp(0, 7); tick_l(7);
        check("mid_level", level, 7);
        #2;
        do_reset();
        check("rst_level", level, 0);
        check("rst_dir", dir, 0);
        ramp(0, 9);
        tick_l(9);
        check("post_err", err_count, 0);
        check("post_dir", dir, 1);

        // Random walk with jumps, bad codes and clears
        do_reset();
        lvl = 0; up = 1;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if (lvl == 0 && $urandom_range(0, 2) == 0) r = 0;
            if (r < 10) begin
                v = bar(lvl);
            end else if (r < 80) begin
                if (lvl == 16) up = 0;
                else if (lvl == 0) up = 1;
                else if ($urandom_range(0, 19) == 0) up = 1 - up;
                lvl = up ? lvl + 1 : lvl - 1;
                v = bar(lvl);
            end else if (r < 86) begin
                lvl = $urandom_range(0, 16);
                v = bar(lvl);
            end else if (r < 93) begin
                v = 16'($urandom);
            end else begin
                lvl = 0;
                v = bar(0);
            end
            tick(v, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
